// File: rtl/calc_pkg.sv
// calc_pkg: shared constants and types for the calc_core_16 execution stage.
//   WIDTH       default operand width
//   op_t        operation codes 0..8 (9..15 are illegal)
//   state_t     control FSM states
//   DIV0_RESULT result presented on a divide by zero
package calc_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_SHL = 4'd7,
    OP_SHR = 4'd8
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2*WIDTH-1:0] DIV0_RESULT = {(2*WIDTH){1'b1}};

endpackage

// File: rtl/muldiv_16.sv
// muldiv_16: iterative multiplier / restoring divider, one bit per cycle.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   go                    load a/b and begin W iterations (counter restarts at 0)
//   is_div                1 = restoring divide, 0 = shift-add multiply (sampled on go)
//   a, b                  multiplier/multiplicand or dividend/divisor
//   busy                  iterations in progress
//   last                  the iteration running this cycle is the final one
//   product               2W-bit product
//   quotient, remainder   divide results
// The outputs show the accumulator value *after* the current iteration, so
// when last is high they already hold the final answer and the caller can
// register them on the same edge that ends the run.
module muldiv_16 import calc_pkg::*; #(
  parameter int W = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           go,
  input  logic           is_div,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           last,
  output logic [2*W-1:0] product,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder
);

  localparam int CW = $clog2(W);

  // Shared accumulator: {high half, low half}. Multiply keeps the partial
  // product in the high half and shifts the multiplier out of the low half
  // (LSB first). Divide keeps the partial remainder in the high half and
  // shifts quotient bits into the low half as dividend bits shift out.
  logic [2*W-1:0] acc;
  logic [W-1:0]   opnd;
  logic           mode_div;
  logic [CW-1:0]  count;
  logic           running;

  logic [W:0]     add_sum;
  logic [W:0]     rem_sh;
  logic [W:0]     diff;
  logic [2*W-1:0] acc_step;

  always_comb begin
    add_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    rem_sh   = acc[2*W-1:W-1];
    diff     = rem_sh - {1'b0, opnd};
    acc_step = acc;
    if (mode_div) begin
      // Partial remainder is always < divisor, so rem_sh fits W+1 bits and
      // diff[W] is a reliable "divisor did not fit" flag.
      if (!diff[W]) acc_step = {diff[W-1:0], acc[W-2:0], 1'b1};
      else          acc_step = {rem_sh[W-1:0], acc[W-2:0], 1'b0};
    end else begin
      acc_step = {add_sum, acc[W-1:1]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      opnd     <= '0;
      mode_div <= 1'b0;
      count    <= '0;
      running  <= 1'b0;
    end else if (go) begin
      acc      <= {{W{1'b0}}, a};
      opnd     <= b;
      mode_div <= is_div;
      count    <= '0;
      running  <= 1'b1;
    end else if (running) begin
      acc   <= acc_step;
      count <= count + 1'b1;
      if (count == CW'(W - 1)) running <= 1'b0;
    end
  end

  assign busy      = running;
  assign last      = running && (count == CW'(W - 1));
  assign product   = acc_step;
  assign quotient  = acc_step[W-1:0];
  assign remainder = acc_step[2*W-1:W];

endmodule

// File: rtl/calc_core_16.sv
// calc_core_16: arithmetic execution stage behind the 16-bit operand loader.
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   num1, num2    operands, latched on an accepted start
//   op            operation code, latched on an accepted start
//   start         request level; a rising edge seen in IDLE starts one op
//   result        registered 2*WIDTH result, held until the next completion
//   done          one-cycle completion pulse (result/error valid)
//   busy          high from the accepted start through the done cycle
//   error         divide by zero or illegal op, registered with result
//   fsm_state     current control state, for observation
// Handshake: start is a level; only its rising edge counts, and only in IDLE.
// Edges arriving while busy are dropped. done is a single-cycle strobe with
// no back-pressure; result/error stay stable until the next done.
module calc_core_16 import calc_pkg::*; #(
  parameter int WIDTH = calc_pkg::WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   num1,
  input  logic [WIDTH-1:0]   num2,
  input  logic [3:0]         op,
  input  logic               start,
  output logic [2*WIDTH-1:0] result,
  output logic               done,
  output logic               busy,
  output logic               error,
  output state_t             fsm_state
);

  localparam int SW = $clog2(WIDTH);

  state_t             state, state_next;
  logic               start_q, trigger;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [3:0]         opc_r;
  logic               load, go, finish, iter_op;
  logic [2*WIDTH-1:0] alu_res, md_res;
  logic               alu_err;
  logic               md_busy, md_last;
  logic [2*WIDTH-1:0] md_product;
  logic [WIDTH-1:0]   md_quotient, md_remainder;
  logic [WIDTH:0]     sum_w, diff_w;

  assign trigger   = start & ~start_q;
  // Divide by zero takes the single-cycle path, so it never starts the iterator.
  assign iter_op   = (opc_r == OP_MUL) || ((opc_r == OP_DIV) && (b_r != '0));
  assign fsm_state = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    go         = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          load       = 1'b1;
          go         = (op == OP_MUL) || ((op == OP_DIV) && (num2 != '0));
          state_next = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (!iter_op || (md_busy && md_last)) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sum_w   = {1'b0, a_r} + {1'b0, b_r};
    diff_w  = {1'b0, a_r} - {1'b0, b_r};
    alu_res = '0;
    alu_err = 1'b0;
    case (opc_r)
      OP_ADD: alu_res = {{(WIDTH-1){1'b0}}, sum_w};
      OP_SUB: alu_res = {{(WIDTH-1){diff_w[WIDTH]}}, diff_w};
      OP_DIV: begin
        alu_res = DIV0_RESULT;
        alu_err = 1'b1;
      end
      OP_AND: alu_res = {{WIDTH{1'b0}}, a_r & b_r};
      OP_OR:  alu_res = {{WIDTH{1'b0}}, a_r | b_r};
      OP_XOR: alu_res = {{WIDTH{1'b0}}, a_r ^ b_r};
      OP_SHL: alu_res = {{WIDTH{1'b0}}, a_r} << b_r[SW-1:0];
      OP_SHR: alu_res = {{WIDTH{1'b0}}, a_r >> b_r[SW-1:0]};
      OP_MUL: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  assign md_res = (opc_r == OP_DIV) ? {md_remainder, md_quotient} : md_product;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start_q <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      opc_r   <= '0;
      result  <= '0;
      error   <= 1'b0;
    end else begin
      start_q <= start;
      if (load) begin
        a_r   <= num1;
        b_r   <= num2;
        opc_r <= op;
      end
      if (finish) begin
        result <= iter_op ? md_res : alu_res;
        error  <= iter_op ? 1'b0 : alu_err;
      end
    end
  end

  muldiv_16 #(.W(WIDTH)) u_muldiv (
    .clock     (clock),
    .reset     (reset),
    .go        (go),
    .is_div    (op == OP_DIV),
    .a         (num1),
    .b         (num2),
    .busy      (md_busy),
    .last      (md_last),
    .product   (md_product),
    .quotient  (md_quotient),
    .remainder (md_remainder)
  );

endmodule
